// File: rtl/preamble_0100_tx_pkg.sv
// Shared definitions for the 0100-preamble serial transmitter.
// State encoding, preamble constants and small helpers.
package preamble_0100_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        STOP = 3'd4
    } state_t;

    localparam logic [3:0] PREAMBLE = 4'b0100;
    localparam int         PRE_LEN  = 4;
    localparam logic [1:0] PRE_LAST = 2'(PRE_LEN - 1);

    // Counter width: enough to hold max(PRE_LEN, data_w) without wrapping.
    function automatic int cnt_width(input int data_w);
        int m;
        m = (data_w > PRE_LEN) ? data_w : PRE_LEN;
        return $clog2(m + 1);
    endfunction

    // Preamble bit number idx, counted from the first bit on the wire.
    function automatic logic pre_bit(input logic [1:0] idx);
        logic [3:0] p;
        p = PREAMBLE;
        return p[PRE_LAST - idx];
    endfunction

endpackage

// File: rtl/preamble_0100_tx_shift.sv
// Payload shifter: parallel load, MSB-first shift,
// running even parity over the bits shifted out.
module frame_shift_reg
    import preamble_0100_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              msb,
    output logic              parity
);

    logic [DATA_W-1:0] sr;
    logic              par;

    // Load a new word, or shift one bit out and fold it into the parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            par <= 1'b0;
        end else if (load) begin
            sr  <= load_data;
            par <= 1'b0;
        end else if (shift) begin
            sr  <= sr << 1;
            par <= par ^ sr[DATA_W-1];
        end
    end

    assign msb    = sr[DATA_W-1];
    assign parity = par;

endmodule

// File: rtl/preamble_0100_tx.sv
// Serial frame transmitter: preamble 0100, payload MSB first,
// optional even parity, one stop bit; idle line high.
module preamble_0100_tx
    import preamble_0100_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              y,
    output logic              busy,
    output logic              frame_done
);

    localparam int            CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0] PRE_END  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_END = CW'(DATA_W - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          y_n;
    logic          accept;
    logic          load;
    logic          shift;
    logic          sr_msb;
    logic          sr_par;

    assign in_ready   = (state == IDLE) || (state == STOP);
    assign accept     = in_valid && in_ready;
    assign busy       = (state == PRE) || (state == DATA) || (state == PAR);
    assign frame_done = (state == STOP);

    frame_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(in_data),
        .shift    (shift),
        .msb      (sr_msb),
        .parity   (sr_par)
    );

    // Next state, counter and the bit y will carry in the next state.
    // A bit is shifted out of the payload register as it is latched into y.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = 1'b1;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE, STOP: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = PRE;
                    y_n     = pre_bit(2'd0);
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            PRE: begin
                if (cnt == PRE_END) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    y_n     = sr_msb;
                    shift   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    y_n   = pre_bit(cnt[1:0] + 2'd1);
                end
            end
            DATA: begin
                if (cnt == DATA_END) begin
                    cnt_n = '0;
                    if (PARITY_EN != 0) begin
                        state_n = PAR;
                        y_n     = sr_par;
                    end else begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    y_n   = sr_msb;
                    shift = 1'b1;
                end
            end
            PAR: begin
                state_n = STOP;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered serial output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end

endmodule
